// File: rtl/case_pkg.sv
// rtl/case_pkg.sv - shared types, character constants and helpers for case_restore
//
// Purpose: state encoding for the sentence-case FSM, the ASCII constants it
// compares against, and pure character-class functions.
// Ports: none (package).

package case_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,  // next letter is a sentence start: emit upper case
    MID   = 2'd1,  // inside a sentence: emit lower case
    PUNCT = 2'd2   // just saw a sentence terminator
  } case_state_e;

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_DOT      = 8'h2E;
  localparam logic [7:0] CH_BANG     = 8'h21;
  localparam logic [7:0] CH_QUEST    = 8'h3F;
  localparam logic [7:0] CH_UPPER_A  = 8'h41;
  localparam logic [7:0] CH_UPPER_Z  = 8'h5A;
  localparam logic [7:0] CH_LOWER_A  = 8'h61;
  localparam logic [7:0] CH_LOWER_Z  = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= CH_UPPER_A) && (c <= CH_UPPER_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= CH_LOWER_A) && (c <= CH_LOWER_Z);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_DOT) || (c == CH_BANG) || (c == CH_QUEST);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - DEPTH x 8 circular-buffer FIFO
//
// Purpose: output queue between the case FSM and a possibly stalling sink.
// Ports:
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-low reset
//   i_push, i_data   write one character (caller guarantees !o_full)
//   i_pop            drop the head entry (caller guarantees !o_empty)
//   o_data           head entry
//   o_full, o_empty  registered-count decodes

module char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (i_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);  // power-of-two depth: wraps to 0
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too so the head reads 0x00 while the queue is empty.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/case_restore.sv
// rtl/case_restore.sv - sentence-case restorer for an all-capitals ASCII stream
//
// Purpose: capitalises the first letter of each sentence and lower-cases every
// other letter, queueing results in an output FIFO with ready/valid handshakes.
// Optional feature macro: CASE_RESTORE_STATS_EN adds o_sent_cnt.
// Ports:
//   i_clk                    clock, rising edge
//   i_rst                    asynchronous active-low reset
//   i_valid, i_char, o_ready upstream handshake (accept = i_valid && o_ready)
//   o_valid, o_char, i_ready downstream handshake (pop = o_valid && i_ready)
//   o_sent_cnt               (CASE_RESTORE_STATS_EN) saturating sentence-start count

module case_restore
  import case_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_char,
  output logic        o_ready,
  output logic        o_valid,
  output logic [7:0]  o_char,
  input  logic        i_ready
`ifdef CASE_RESTORE_STATS_EN
  ,
  output logic [15:0] o_sent_cnt
`endif
);

  case_state_e state_q, state_d;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        pop;
  logic        in_upper;
  logic        in_lower;
  logic        in_letter;
  logic [7:0]  out_char;

  // Handshake decodes come only from the registered FIFO count.
  assign o_ready = !fifo_full;
  assign o_valid = !fifo_empty;
  assign accept  = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    in_upper  = is_upper(i_char);
    in_lower  = is_lower(i_char);
    in_letter = in_upper || in_lower;

    out_char = i_char;
    if ((state_q == START) && in_lower) begin
      out_char = i_char - CASE_OFFSET;
    end else if ((state_q != START) && in_upper) begin
      out_char = i_char + CASE_OFFSET;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (i_char == CH_LF) begin
        state_d = START;
      end else begin
        case (state_q)
          START: state_d = in_letter ? MID : START;
          MID:   state_d = is_term(i_char) ? PUNCT : MID;
          PUNCT: begin
            if (i_char == CH_SPACE) begin
              state_d = START;
            end else if (is_term(i_char)) begin
              state_d = PUNCT;
            end else begin
              // Terminator not followed by a space (e.g. "3.14"): not a sentence end.
              state_d = MID;
            end
          end
          default: state_d = START;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_data  (out_char),
    .i_pop   (pop),
    .o_data  (o_char),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

`ifdef CASE_RESTORE_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;

  always_comb begin
    sent_cnt_d = sent_cnt_q;
    if (accept && (state_q == START) && in_letter && (sent_cnt_q != 16'hFFFF)) begin
      sent_cnt_d = sent_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sent_cnt_q <= 16'h0000;
    end else begin
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign o_sent_cnt = sent_cnt_q;
`endif

endmodule

// File: tb/tb_case_restore.sv
// tb/tb_case_restore.sv - directed self-checking bench for case_restore

module tb_case_restore;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_char;
  logic        o_ready;
  logic        o_valid;
  logic [7:0]  o_char;
  logic        i_ready;
`ifdef CASE_RESTORE_STATS_EN
  logic [15:0] o_sent_cnt;
`endif

  int vectors;
  int miscompares;

  case_restore #(.DEPTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_char  (i_char),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_char  (o_char),
    .i_ready (i_ready)
`ifdef CASE_RESTORE_STATS_EN
    ,
    .o_sent_cnt (o_sent_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset pulse, checked before any clock edge can intervene.
  task automatic do_reset(input string tag);
    i_valid = 1'b1;
    i_char  = 8'h5A;
    i_ready = 1'b1;
    i_rst   = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_char"},  32'(o_char),  32'h00);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    check({tag, "_hold_valid"}, 32'(o_valid), 32'd0);
    i_valid = 1'b0;
    i_char  = 8'h00;
    i_rst   = 1'b1;
    @(posedge i_clk); #1;
  endtask

  // One character per cycle with i_ready high: FIFO never holds more than
  // the latest entry, so it must be the head one cycle after acceptance.
  task automatic stream_step(input string in_s, input string exp_s, input string tag);
    for (int k = 0; k < in_s.len(); k++) begin
      i_valid = 1'b1;
      i_char  = in_s[k];
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      check($sformatf("%s_v%0d", tag, k), 32'(o_valid), 32'd1);
      check($sformatf("%s_c%0d", tag, k), 32'(o_char), 32'(exp_s[k]));
    end
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    check({tag, "_drained"}, 32'(o_valid), 32'd0);
  endtask

  // Scoreboarded stream: pushes in_s, compares every pop against exp_s in order.
  task automatic run(input string in_s, input string exp_s, input bit toggle,
                     input int max_cyc, input bit drain, input string tag);
    int pi;
    int po;
    bit rdy;
    bit push;
    pi  = 0;
    po  = 0;
    rdy = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (drain && (pi >= in_s.len()) && (po >= exp_s.len()) && !o_valid) break;
      i_valid = (pi < in_s.len());
      i_char  = i_valid ? in_s[pi] : 8'h00;
      i_ready = rdy;
      if (o_valid && i_ready) begin
        check($sformatf("%s_pop%0d", tag, po), 32'(o_char), 32'(exp_s[po]));
        po++;
      end
      push = i_valid && o_ready;
      @(posedge i_clk); #1;
      if (push) pi++;
      if (toggle) rdy = !rdy;
    end
    i_valid = 1'b0;
    if (drain) begin
      check({tag, "_npop"}, 32'(po), 32'(exp_s.len()));
      check({tag, "_empty"}, 32'(o_valid), 32'd0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_char  = 8'h00;
    i_ready = 1'b0;
    #2;

    // Reset with stimulus active, then first letter stays upper case.
    do_reset("rst0");
`ifdef CASE_RESTORE_STATS_EN
    check("stats_rst0", 32'(o_sent_cnt), 32'd0);
`endif
    stream_step("A", "A", "first");

    do_reset("rst1");
    stream_step("HELLO. WORLD", "Hello. World", "sent");
`ifdef CASE_RESTORE_STATS_EN
    check("stats_sent", 32'(o_sent_cnt), 32'd2);
`endif

    do_reset("rst2");
    stream_step("PI 3.14 IS", "Pi 3.14 is", "pi");

    do_reset("rst3");
    stream_step("OK!!\nGO", "Ok!!\nGo", "nl");

    // Backpressure: fill the 4-entry FIFO with the sink stalled.
    do_reset("rst4");
    begin
      string bp;
      bp = "ABCD";
      i_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        i_valid = 1'b1;
        i_char  = bp[k];
        @(posedge i_clk); #1;
        check($sformatf("bp_ready%0d", k), 32'(o_ready), (k < 3) ? 32'd1 : 32'd0);
        check($sformatf("bp_head%0d", k), 32'(o_char), 32'h41);
      end
      i_char = 8'h45;
      for (int k = 0; k < 2; k++) begin
        @(posedge i_clk); #1;
        check($sformatf("bp_full%0d", k), 32'(o_ready), 32'd0);
        check($sformatf("bp_hold%0d", k), 32'(o_char), 32'h41);
      end
    end
    run("E", "Abcde", 1'b0, 20, 1'b1, "bp");

    // Mid-stream reset with toggling sink, then FSM must be back in START.
    do_reset("rst5");
    run("AB. CD", "Ab. Cd", 1'b1, 4, 1'b0, "mid");
    check("mid_pre_valid", 32'(o_valid), 32'd1);
    do_reset("rst6");
`ifdef CASE_RESTORE_STATS_EN
    check("stats_rst6", 32'(o_sent_cnt), 32'd0);
`endif
    stream_step("XY", "Xy", "post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
